cnt_reg_checker: RTL and testbench
==================================

CNT_REG_CHECKER -- requirements
Module: cnt_reg_checker

Interface
REQ-001 SHALL have parameter D_BIT, default 8: data width of the checked counter register.
REQ-002 SHALL have parameter ERR_W, default 16: width of the error and compare counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port chk_en, input, 1: 1 = compares counted and flagged; 0 = golden model still tracks, no compare.
REQ-006 SHALL have port dut_rst, input, 1: the DUT's synchronous reset, as driven to the DUT.
REQ-007 SHALL have port en, input, 1: the DUT's load enable.
REQ-008 SHALL have port en_count, input, 1: the DUT's load-and-increment enable.
REQ-009 SHALL have port d, input, D_BIT: the DUT's data input.
REQ-010 SHALL have port q, input, D_BIT: the DUT's registered output under check.
REQ-011 SHALL have port err, output, 1: one-cycle mismatch pulse.
REQ-012 SHALL have port err_sticky, output, 1: set on the first mismatch; held until reset or clr.
REQ-013 SHALL have port clr, input, 1: synchronous clear of the counters, the sticky flag and the capture.
REQ-014 SHALL have port err_cnt, output, ERR_W: saturating mismatch count.
REQ-015 SHALL have port chk_cnt, output, ERR_W: saturating count of compares performed.
REQ-016 SHALL have port gold, output, D_BIT: current golden value.
REQ-017 SHALL have port gold_vld, output, 1: golden value defined.
REQ-018 SHALL have ports fe_vld (1), fe_exp (D_BIT), fe_got (D_BIT) and fe_cyc (ERR_W), all outputs: first-error capture.

Function
REQ-019 Golden update at every rising edge, priority dut_rst > en_count > en > hold: dut_rst gives 0; en_count gives d+1 modulo 2^D_BIT; en gives d; otherwise gold holds.
REQ-020 gold_vld SHALL clear on reset and set at the first edge on which dut_rst, en or en_count is 1; clr SHALL NOT affect gold or gold_vld.
REQ-021 Compare at edge k SHALL use q sampled at edge k against gold as registered at edge k-1, so the DUT's one-cycle latency is modelled exactly.
REQ-022 A compare SHALL occur when gold_vld=1 and chk_en=1; each compare SHALL increment chk_cnt.
REQ-023 On a compare where q != gold, the block SHALL assert err for exactly the following cycle, set err_sticky and increment err_cnt.
REQ-024 err_cnt and chk_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-025 If clr and a mismatch occur on the same edge, the mismatch SHALL win: err_cnt=1, chk_cnt=1, err_sticky=1, err=1.
REQ-026 A golden update and a compare on the same edge SHALL both take effect; the compare uses the old gold.
REQ-027 When chk_en=0, err, err_cnt and chk_cnt SHALL hold or stay low, while gold keeps tracking.

Reset
REQ-028 Asserting rst SHALL immediately clear every output and register to 0 (gold, gold_vld, err, err_sticky, err_cnt, chk_cnt, fe_*), independent of clk.
REQ-029 On rst deassertion, the first compare SHALL be no earlier than the edge after gold_vld sets.

Configuration
REQ-030 Macro CNT_CHK_FIRST_ERR_EN, when defined: at the first mismatch after reset or clr, the block SHALL latch fe_exp=gold, fe_got=q and fe_cyc=chk_cnt value including this compare, and set fe_vld; later mismatches SHALL NOT overwrite the capture.
REQ-031 CNT_CHK_FIRST_ERR_EN undefined: fe_vld, fe_exp, fe_got and fe_cyc SHALL remain present and be driven constant 0; no capture logic.

Verification
REQ-032 rst low mid-run with err_cnt=5: all outputs become 0 asynchronously before the next edge.
REQ-033 D_BIT=8: dut_rst, then en with d=0x3C, then en_count with d=0xFF, with q following correctly: gold reads 0x00, 0x3C, 0x00 (wrap); err_cnt=0; chk_cnt=2.
REQ-034 Golden sequence as in REQ-033, with q forced to 0x3D where 0x3C is expected: err high for one cycle, err_sticky=1, err_cnt=1; with the macro defined, fe_exp=0x3C, fe_got=0x3D, fe_cyc=1.
REQ-035 Second mismatch with q=0x11 against expected 0x12: err_cnt=2 and the capture is unchanged (fe_got still 0x3D).
REQ-036 ERR_W=4: 20 consecutive mismatches: err_cnt=15 and held; clr together with one further mismatch gives err_cnt=1.
REQ-037 chk_en=0 for 3 cycles with q wrong: err stays 0 and the counters are unchanged; after re-enable, a correct q gives no error.

Source files
------------

// File: rtl/cnt_reg_checker.sv
// Shadow checker for a loadable counter register: keeps a golden copy of the DUT's
// next value and compares it one cycle later. Optional first-error capture: CNT_CHK_FIRST_ERR_EN.
module cnt_reg_checker #(
    parameter int D_BIT = 8,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             dut_rst,
    input  logic             en,
    input  logic             en_count,
    input  logic [D_BIT-1:0] d,
    input  logic [D_BIT-1:0] q,
    input  logic             clr,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] chk_cnt,
    output logic [D_BIT-1:0] gold,
    output logic             gold_vld,
    output logic             fe_vld,
    output logic [D_BIT-1:0] fe_exp,
    output logic [D_BIT-1:0] fe_got,
    output logic [ERR_W-1:0] fe_cyc
);

    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    logic [D_BIT-1:0] gold_q, gold_d;
    logic             gold_vld_q, gold_vld_d;
    logic             err_q, err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] chk_cnt_q, chk_cnt_d;

    logic             do_cmp;
    logic             mismatch;
    logic [ERR_W-1:0] err_base;
    logic [ERR_W-1:0] chk_base;

    // Golden model of the DUT register, same priority as the DUT itself.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        gold_d     = gold_q;
        gold_vld_d = gold_vld_q | dut_rst | en | en_count;
        if (dut_rst) begin
            gold_d = '0;
        end else if (en_count) begin
            gold_d = d + D_BIT'(1);
        end else if (en) begin
            gold_d = d;
        end
    end

    // q sampled now is checked against the gold registered on the previous edge.
    assign do_cmp   = gold_vld_q & chk_en;
    assign mismatch = do_cmp & (q != gold_q);

    // clr zeroes the base, then this edge's compare is applied on top, so a
    // coincident mismatch is never lost.
    always_comb begin
        err_base     = clr ? '0 : err_cnt_q;
        chk_base     = clr ? '0 : chk_cnt_q;
        err_cnt_d    = err_base;
        chk_cnt_d    = chk_base;
        if (do_cmp && chk_base != CNT_MAX) begin
            chk_cnt_d = chk_base + ERR_W'(1);
        end
        if (mismatch && err_base != CNT_MAX) begin
            err_cnt_d = err_base + ERR_W'(1);
        end
        err_sticky_d = (err_sticky_q & ~clr) | mismatch;
        err_d        = mismatch;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gold_q       <= '0;
            gold_vld_q   <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            gold_q       <= gold_d;
            gold_vld_q   <= gold_vld_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
        end
    end

    assign gold       = gold_q;
    assign gold_vld   = gold_vld_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign chk_cnt    = chk_cnt_q;

`ifdef CNT_CHK_FIRST_ERR_EN
    logic             fe_vld_q, fe_vld_d;
    logic [D_BIT-1:0] fe_exp_q, fe_exp_d;
    logic [D_BIT-1:0] fe_got_q, fe_got_d;
    logic [ERR_W-1:0] fe_cyc_q, fe_cyc_d;

    // Only the first mismatch after reset or clr is captured; fe_cyc includes that compare.
    always_comb begin
        fe_vld_d = fe_vld_q & ~clr;
        fe_exp_d = clr ? '0 : fe_exp_q;
        fe_got_d = clr ? '0 : fe_got_q;
        fe_cyc_d = clr ? '0 : fe_cyc_q;
        if (mismatch && !fe_vld_d) begin
            fe_vld_d = 1'b1;
            fe_exp_d = gold_q;
            fe_got_d = q;
            fe_cyc_d = chk_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fe_vld_q <= 1'b0;
            fe_exp_q <= '0;
            fe_got_q <= '0;
            fe_cyc_q <= '0;
        end else begin
            fe_vld_q <= fe_vld_d;
            fe_exp_q <= fe_exp_d;
            fe_got_q <= fe_got_d;
            fe_cyc_q <= fe_cyc_d;
        end
    end

    assign fe_vld = fe_vld_q;
    assign fe_exp = fe_exp_q;
    assign fe_got = fe_got_q;
    assign fe_cyc = fe_cyc_q;
`else
    assign fe_vld = 1'b0;
    assign fe_exp = '0;
    assign fe_got = '0;
    assign fe_cyc = '0;
`endif

endmodule

// File: tb/tb_cnt_reg_checker.sv
// Bench for cnt_reg_checker: vector table through a scoreboard queue on the default
// instance, plus hand-written reset and saturation sequences (ERR_W=4 instance).
module tb_cnt_reg_checker;

    typedef struct {
        logic       dr, en, ec;
        logic [7:0] d, q;
        logic       ce, clr;
        logic [7:0] gold;
        logic       gvld, err, sticky;
        logic [15:0] ecnt, ccnt;
        logic       fe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Default instance (D_BIT=8, ERR_W=16)
    logic        a_ce = 0, a_dr = 0, a_en = 0, a_ec = 0, a_clr = 0;
    logic [7:0]  a_d = 0, a_q = 0;
    logic        a_err, a_sticky, a_gvld, a_fe_vld;
    logic [15:0] a_ecnt, a_ccnt, a_fe_cyc;
    logic [7:0]  a_gold, a_fe_exp, a_fe_got;

    cnt_reg_checker u_a (
        .clk(clk), .rst(rst), .chk_en(a_ce), .dut_rst(a_dr), .en(a_en), .en_count(a_ec),
        .d(a_d), .q(a_q), .err(a_err), .err_sticky(a_sticky), .clr(a_clr),
        .err_cnt(a_ecnt), .chk_cnt(a_ccnt), .gold(a_gold), .gold_vld(a_gvld),
        .fe_vld(a_fe_vld), .fe_exp(a_fe_exp), .fe_got(a_fe_got), .fe_cyc(a_fe_cyc)
    );

    // Narrow-counter instance for saturation
    logic       b_ce = 0, b_dr = 0, b_en = 0, b_ec = 0, b_clr = 0;
    logic [7:0] b_d = 0, b_q = 0;
    logic       b_err, b_sticky, b_gvld, b_fe_vld;
    logic [3:0] b_ecnt, b_ccnt, b_fe_cyc;
    logic [7:0] b_gold, b_fe_exp, b_fe_got;

    cnt_reg_checker #(.D_BIT(8), .ERR_W(4)) u_b (
        .clk(clk), .rst(rst), .chk_en(b_ce), .dut_rst(b_dr), .en(b_en), .en_count(b_ec),
        .d(b_d), .q(b_q), .err(b_err), .err_sticky(b_sticky), .clr(b_clr),
        .err_cnt(b_ecnt), .chk_cnt(b_ccnt), .gold(b_gold), .gold_vld(b_gvld),
        .fe_vld(b_fe_vld), .fe_exp(b_fe_exp), .fe_got(b_fe_got), .fe_cyc(b_fe_cyc)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected first-error capture of instance A; zero when the feature is compiled out.
    task automatic check_fe_a(input string tag, input logic vld, input logic [7:0] e,
                              input logic [7:0] g, input logic [15:0] c);
`ifdef CNT_CHK_FIRST_ERR_EN
        check({tag, " fe_vld"}, a_fe_vld, vld);
        check({tag, " fe_exp"}, a_fe_exp, vld ? e : 8'h00);
        check({tag, " fe_got"}, a_fe_got, vld ? g : 8'h00);
        check({tag, " fe_cyc"}, a_fe_cyc, vld ? c : 16'h0);
`else
        check({tag, " fe_vld"}, a_fe_vld, 1'b0);
        check({tag, " fe_exp"}, a_fe_exp, 8'h00);
        check({tag, " fe_got"}, a_fe_got, 8'h00);
        check({tag, " fe_cyc"}, a_fe_cyc, 16'h0);
`endif
    endtask

    task automatic b_step(input logic dr, input logic ce, input logic clr, input logic [7:0] q);
        b_dr = dr; b_ce = ce; b_clr = clr; b_q = q;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[18];
        vec_t exp_q[$];
        vec_t e;

        //           dr en ec d      q      ce clr  gold   gv err st ecnt ccnt fe
        vecs[0]  = '{1, 0, 0, 8'h00, 8'hAA, 1, 0,   8'h00, 1, 0, 0, 16'd0, 16'd0, 0};
        vecs[1]  = '{0, 1, 0, 8'h3C, 8'h00, 1, 0,   8'h3C, 1, 0, 0, 16'd0, 16'd1, 0};
        vecs[2]  = '{0, 0, 1, 8'hFF, 8'h3C, 1, 0,   8'h00, 1, 0, 0, 16'd0, 16'd2, 0};
        vecs[3]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0,   8'h00, 1, 0, 0, 16'd0, 16'd2, 0};
        vecs[4]  = '{1, 0, 0, 8'h00, 8'h00, 0, 1,   8'h00, 1, 0, 0, 16'd0, 16'd0, 0};
        vecs[5]  = '{0, 1, 0, 8'h3C, 8'h00, 0, 0,   8'h3C, 1, 0, 0, 16'd0, 16'd0, 0};
        vecs[6]  = '{0, 0, 1, 8'hFF, 8'h3D, 1, 0,   8'h00, 1, 1, 1, 16'd1, 16'd1, 1};
        vecs[7]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0,   8'h00, 1, 0, 1, 16'd1, 16'd1, 1};
        vecs[8]  = '{0, 1, 0, 8'h12, 8'h00, 0, 0,   8'h12, 1, 0, 1, 16'd1, 16'd1, 1};
        vecs[9]  = '{0, 0, 0, 8'h00, 8'h11, 1, 0,   8'h12, 1, 1, 1, 16'd2, 16'd2, 1};
        vecs[10] = '{0, 0, 0, 8'h00, 8'h12, 1, 0,   8'h12, 1, 0, 1, 16'd2, 16'd3, 1};
        vecs[11] = '{0, 0, 0, 8'h00, 8'h55, 0, 0,   8'h12, 1, 0, 1, 16'd2, 16'd3, 1};
        vecs[12] = '{0, 0, 0, 8'h00, 8'h55, 0, 0,   8'h12, 1, 0, 1, 16'd2, 16'd3, 1};
        vecs[13] = '{0, 0, 0, 8'h00, 8'h55, 0, 0,   8'h12, 1, 0, 1, 16'd2, 16'd3, 1};
        vecs[14] = '{0, 0, 0, 8'h00, 8'h12, 1, 0,   8'h12, 1, 0, 1, 16'd2, 16'd4, 1};
        vecs[15] = '{0, 1, 1, 8'h7F, 8'h00, 0, 0,   8'h80, 1, 0, 1, 16'd2, 16'd4, 1};
        vecs[16] = '{1, 1, 1, 8'h7F, 8'h00, 0, 0,   8'h00, 1, 0, 1, 16'd2, 16'd4, 1};
        vecs[17] = '{0, 0, 0, 8'h00, 8'h00, 0, 1,   8'h00, 1, 0, 0, 16'd0, 16'd0, 0};

        // Reset state
        #12;
        check("rst gold", a_gold, 8'h00);
        check("rst gold_vld", a_gvld, 1'b0);
        check("rst err", a_err, 1'b0);
        check("rst err_cnt", a_ecnt, 16'd0);
        check("rst chk_cnt", a_ccnt, 16'd0);
        check_fe_a("rst", 1'b0, 8'h00, 8'h00, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: drive before the edge, compare at the following negedge
        for (int i = 0; i < 18; i++) begin
            a_dr = vecs[i].dr; a_en = vecs[i].en; a_ec = vecs[i].ec;
            a_d  = vecs[i].d;  a_q  = vecs[i].q;  a_ce = vecs[i].ce; a_clr = vecs[i].clr;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d gold", i), a_gold, e.gold);
            check($sformatf("v%0d gold_vld", i), a_gvld, e.gvld);
            check($sformatf("v%0d err", i), a_err, e.err);
            check($sformatf("v%0d err_sticky", i), a_sticky, e.sticky);
            check($sformatf("v%0d err_cnt", i), a_ecnt, e.ecnt);
            check($sformatf("v%0d chk_cnt", i), a_ccnt, e.ccnt);
            check_fe_a($sformatf("v%0d", i), e.fe, 8'h3C, 8'h3D, 16'd1);
        end
        a_dr = 0; a_en = 0; a_ec = 0; a_clr = 0;

        // Five mismatches (gold 00, q 01), then asynchronous reset between edges
        a_ce = 1; a_q = 8'h01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        a_ce = 0;
        check("pre-rst err_cnt", a_ecnt, 16'd5);
        check_fe_a("pre-rst", 1'b1, 8'h00, 8'h01, 16'd1);
        #2 rst = 1'b0;
        #1;
        check("async rst gold_vld", a_gvld, 1'b0);
        check("async rst err", a_err, 1'b0);
        check("async rst err_sticky", a_sticky, 1'b0);
        check("async rst err_cnt", a_ecnt, 16'd0);
        check("async rst chk_cnt", a_ccnt, 16'd0);
        check_fe_a("async rst", 1'b0, 8'h00, 8'h00, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // First edge after reset with chk_en already high: no compare before gold_vld
        a_ce = 1; a_dr = 1; a_q = 8'h77;
        @(posedge clk);
        @(negedge clk);
        a_ce = 0; a_dr = 0;
        check("post-rst first chk_cnt", a_ccnt, 16'd0);
        check("post-rst first err", a_err, 1'b0);

        // ERR_W=4 saturation
        b_step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) b_step(1'b0, 1'b1, 1'b0, 8'h01);
        check("sat err_cnt", b_ecnt, 4'd15);
        check("sat chk_cnt", b_ccnt, 4'd15);
        check("sat err", b_err, 1'b1);
        b_step(1'b0, 1'b1, 1'b0, 8'h01);
        check("sat held err_cnt", b_ecnt, 4'd15);
        b_step(1'b0, 1'b1, 1'b1, 8'h01);
        check("clr+mis err_cnt", b_ecnt, 4'd1);
        check("clr+mis chk_cnt", b_ccnt, 4'd1);
        check("clr+mis err_sticky", b_sticky, 1'b1);
        check("clr+mis err", b_err, 1'b1);
`ifdef CNT_CHK_FIRST_ERR_EN
        check("clr+mis fe_vld", b_fe_vld, 1'b1);
        check("clr+mis fe_got", b_fe_got, 8'h01);
        check("clr+mis fe_cyc", b_fe_cyc, 4'd1);
`else
        check("clr+mis fe_vld", b_fe_vld, 1'b0);
`endif
        b_step(1'b0, 1'b0, 1'b0, 8'h00);
        check("err pulse drop", b_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
